// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, size codes and lookup constants for the data cache
package dcache_pkg;

    localparam int INDEX_W = 7;
    localparam int TAG_HI  = 16;
    localparam int IO_HI   = 17;
    localparam int DEPTH   = 1 << INDEX_W;
    localparam int TAG_W   = TAG_HI - (INDEX_W + 2) + 1;

    localparam logic        HIT       = 1'b1;
    localparam logic        MISS      = 1'b0;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } wsize_e;

    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0]   tag_t;

endpackage

// File: rtl/dcache_lane_merge.sv
// rtl/dcache_lane_merge.sv - byte-enable generation and lane merge of store data into a cached word
module dcache_lane_merge
    import dcache_pkg::*;
(
    input  logic [31:0] old_data,
    input  logic [31:0] wdata,
    input  wsize_e      size,
    input  logic [1:0]  offset,
    output logic [3:0]  be,
    output logic [31:0] merged
);

    always_comb begin
        be = 4'b0000;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = 4'b0011 << offset;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
    end

    // Sub-word data is LSB-aligned: the lane at the offset takes byte 0, the next lane byte 1
    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                if (size == SIZE_WORD)
                    merged[8*i +: 8] = wdata[8*i +: 8];
                else if (2'(i) == offset)
                    merged[8*i +: 8] = wdata[7:0];
                else
                    merged[8*i +: 8] = wdata[15:8];
            end
        end
    end

endmodule

// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped write-through word cache with combinational lookup for the MEM load path
module dcache
    import dcache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        re_i,
    input  logic [31:0] raddr_i,
    output logic        hit_o,
    output logic [31:0] data_o,
    input  logic        we_i,
    input  logic [1:0]  wsize_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i
);

    logic [DEPTH-1:0] valid;
    tag_t             tag_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    idx_t        ridx;
    tag_t        rtag;
    logic        lookup_hit;

    idx_t        widx, widx2;
    tag_t        wtag, wtag2;
    logic [31:0] waddr_next;
    wsize_e      size;
    logic [1:0]  offset;
    logic        hit1, hit2, span;
    logic        do_alloc, do_merge, do_inval1, do_inval2;
    logic [3:0]  be;
    logic [31:0] merged;
    logic        unused_bits;

    assign ridx = raddr_i[INDEX_W+1:2];
    assign rtag = raddr_i[TAG_HI:INDEX_W+2];

    assign lookup_hit = re_i && (raddr_i[1:0] == 2'b00) && !raddr_i[IO_HI]
                        && valid[ridx] && (tag_mem[ridx] == rtag);
    assign hit_o  = lookup_hit ? HIT : MISS;
    assign data_o = lookup_hit ? data_mem[ridx] : ZERO_WORD;

    // The second word of a spanning store; its index wraps naturally via the slice
    assign waddr_next = waddr_i + 32'd4;
    assign widx   = waddr_i[INDEX_W+1:2];
    assign wtag   = waddr_i[TAG_HI:INDEX_W+2];
    assign widx2  = waddr_next[INDEX_W+1:2];
    assign wtag2  = waddr_next[TAG_HI:INDEX_W+2];
    assign size   = wsize_e'(wsize_i);
    assign offset = waddr_i[1:0];

    assign hit1 = valid[widx]  && (tag_mem[widx]  == wtag);
    assign hit2 = valid[widx2] && (tag_mem[widx2] == wtag2);
    assign span = ((size == SIZE_WORD) && (offset != 2'b00))
               || ((size == SIZE_HALF) && (offset == 2'b11));

    dcache_lane_merge u_lane_merge (
        .old_data (data_mem[widx]),
        .wdata    (wdata_i),
        .size     (size),
        .offset   (offset),
        .be       (be),
        .merged   (merged)
    );

    always_comb begin
        do_alloc  = 1'b0;
        do_merge  = 1'b0;
        do_inval1 = 1'b0;
        do_inval2 = 1'b0;
        if (we_i && !waddr_i[IO_HI]) begin
            if (span) begin
                do_inval1 = hit1;
                do_inval2 = hit2;
            end else if (size == SIZE_WORD) begin
                do_alloc = 1'b1;
            end else begin
                // Reserved size yields no enabled lanes and therefore no update
                do_merge = hit1 && (be != 4'b0000);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (do_alloc)  valid[widx]  <= 1'b1;
            if (do_inval1) valid[widx]  <= 1'b0;
            if (do_inval2) valid[widx2] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_alloc) begin
                tag_mem[widx]  <= wtag;
                data_mem[widx] <= wdata_i;
            end else if (do_merge) begin
                data_mem[widx] <= merged;
            end
        end
    end

    assign unused_bits = ^{raddr_i[31:IO_HI+1], waddr_i[31:IO_HI+1],
                           waddr_next[31:TAG_HI+1], waddr_next[1:0]};

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - scoreboard bench: directed cases then random traffic against a byte-level cache model
module tb_dcache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        re_i;
    logic [31:0] raddr_i;
    logic        hit_o;
    logic [31:0] data_o;
    logic        we_i;
    logic [1:0]  wsize_i;
    logic [31:0] waddr_i;
    logic [31:0] wdata_i;

    always #5 clk = ~clk;

    dcache dut (
        .clk     (clk),
        .rst     (rst),
        .re_i    (re_i),
        .raddr_i (raddr_i),
        .hit_o   (hit_o),
        .data_o  (data_o),
        .we_i    (we_i),
        .wsize_i (wsize_i),
        .waddr_i (waddr_i),
        .wdata_i (wdata_i)
    );

    typedef struct {
        logic        hit;
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model: each of the 128 slots remembers which word (address bits 16:2) it holds
    bit          m_valid [128];
    int unsigned m_word  [128];
    logic [31:0] m_data  [128];

    function automatic exp_t m_lookup(input logic [31:0] a);
        exp_t e;
        int unsigned w = a >> 2;
        int unsigned i = w % 128;
        e.addr = a;
        e.hit  = 1'b0;
        e.data = 32'h0;
        if (a[1:0] == 2'b00 && !a[17] && m_valid[i] && m_word[i] == (w & 32'h7FFF)) begin
            e.hit  = 1'b1;
            e.data = m_data[i];
        end
        return e;
    endfunction

    function automatic void m_drop(input int unsigned w);
        int unsigned i = w % 128;
        if (m_valid[i] && m_word[i] == (w & 32'h7FFF)) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        int unsigned wa = a >> 2;
        int unsigned wb = (a + n - 1) >> 2;
        int unsigned i  = wa % 128;
        if (n == 0 || a[17]) return;
        if (n == 4 && a[1:0] == 2'b00) begin
            m_valid[i] = 1'b1;
            m_word[i]  = wa & 32'h7FFF;
            m_data[i]  = d;
        end else if (wa != wb) begin
            m_drop(wa);
            m_drop(wb);
        end else if (m_valid[i] && m_word[i] == (wa & 32'h7FFF)) begin
            for (int k = 0; k < int'(n); k++) begin
                int unsigned lane = (a + k) % 4;
                m_data[i][lane*8 +: 8] = d[k*8 +: 8];
            end
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic do_read(input logic [31:0] a);
        @(posedge clk); #1;
        rst = 1'b0; we_i = 1'b0; re_i = 1'b1; raddr_i = a;
        sb.push_back(m_lookup(a));
    endtask

    task automatic do_read_exp(input logic [31:0] a, input logic h, input logic [31:0] d);
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b0; we_i = 1'b0; re_i = 1'b1; raddr_i = a;
        e.addr = a; e.hit = h; e.data = d;
        sb.push_back(e);
    endtask

    task automatic do_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rst = 1'b0; re_i = 1'b0; we_i = 1'b1;
        wsize_i = sz; waddr_i = a; wdata_i = d; raddr_i = a;
        m_write(sz, a, d);
    endtask

    task automatic do_reset(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        rst = 1'b1; re_i = 1'b0; we_i = w;
        wsize_i = 2'd2; waddr_i = a; wdata_i = d;
        m_reset();
    endtask

    task automatic do_idle();
        @(posedge clk); #1;
        rst = 1'b0; re_i = 1'b0; we_i = 1'b0; raddr_i = $urandom();
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned idxs [6] = '{0, 1, 2, 64, 126, 127};
        logic [31:0] a;
        a = 32'(($urandom_range(0, 2) << 9) | (idxs[$urandom_range(0, 5)] << 2));
        if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = a | 32'h0002_0000;
        if ($urandom_range(0, 15) == 0) a = a | ($urandom() & 32'hFFFC_0000);
        return a;
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (re_i) begin
                compared++;
                if (sb.size() == 0) begin
                    mismatched++;
                    $display("FAIL lookup_unexpected addr=%h: got hit=%0b data=%h, want no lookup", raddr_i, hit_o, data_o);
                end else begin
                    mon_e = sb.pop_front();
                    if (hit_o !== mon_e.hit || data_o !== mon_e.data) begin
                        mismatched++;
                        $display("FAIL lookup addr=%h: got hit=%0b data=%h, want hit=%0b data=%h",
                                 mon_e.addr, hit_o, data_o, mon_e.hit, mon_e.data);
                    end
                end
            end else begin
                compared++;
                if (hit_o !== MISS || data_o !== ZERO_WORD) begin
                    mismatched++;
                    $display("FAIL idle_miss raddr=%h: got hit=%0b data=%h, want hit=0 data=00000000", raddr_i, hit_o, data_o);
                end
            end
        end
    end

    initial begin
        int r;
        rst = 1'b1; re_i = 1'b0; we_i = 1'b0; wsize_i = 2'd0;
        raddr_i = 32'h0; waddr_i = 32'h0; wdata_i = 32'h0;
        m_reset();
        do_reset(1'b0, 32'h0, 32'h0);
        do_reset(1'b0, 32'h0, 32'h0);

        do_read_exp(32'h100, MISS, 32'h0);
        do_write(2'd2, 32'h100, 32'hDEADBEEF);
        do_read_exp(32'h100, HIT, 32'hDEADBEEF);
        do_read_exp(32'h102, MISS, 32'h0);
        do_write(2'd0, 32'h101, 32'h55);
        do_read_exp(32'h100, HIT, 32'hDEAD55EF);
        do_write(2'd1, 32'h102, 32'h1234);
        do_read_exp(32'h100, HIT, 32'h123455EF);
        do_write(2'd0, 32'h205, 32'h77);
        do_read_exp(32'h204, MISS, 32'h0);

        do_write(2'd2, 32'h100, 32'h11111111);
        do_write(2'd2, 32'h300, 32'h22222222);
        do_read_exp(32'h100, MISS, 32'h0);
        do_read_exp(32'h300, HIT, 32'h22222222);
        do_write(2'd2, 32'h304, 32'h33333333);
        do_read_exp(32'h304, HIT, 32'h33333333);
        do_write(2'd2, 32'h302, 32'hCAFEF00D);
        do_read_exp(32'h300, MISS, 32'h0);
        do_read_exp(32'h304, MISS, 32'h0);

        do_write(2'd2, 32'h30000, 32'h0000AAAA);
        do_read_exp(32'h30000, MISS, 32'h0);

        do_write(2'd2, 32'h1FC, 32'h44444444);
        do_write(2'd2, 32'h000, 32'h55555555);
        do_write(2'd1, 32'h1FF, 32'h0000BEEF);
        do_read_exp(32'h1FC, MISS, 32'h0);
        do_read_exp(32'h000, HIT, 32'h55555555);

        do_write(2'd2, 32'h500, 32'h77777777);
        do_write(2'd3, 32'h500, 32'h88888888);
        do_read_exp(32'h500, HIT, 32'h77777777);

        do_write(2'd2, 32'h100, 32'h66666666);
        do_read_exp(32'h100, HIT, 32'h66666666);
        do_reset(1'b1, 32'h104, 32'h99999999);
        do_read_exp(32'h100, MISS, 32'h0);
        do_read_exp(32'h104, MISS, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 45) begin
                do_read(rand_addr());
            end else if (r < 93) begin
                r = $urandom_range(0, 9);
                do_write((r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
                         rand_addr(), $urandom());
            end else if (r < 95) begin
                do_reset(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            end else begin
                do_idle();
            end
        end

        do_idle();
        do_idle();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dcache.md
Name: dcache

Overview:
- Direct-mapped, write-through data cache serving the MEM stage's load path.
- MEM presents a registered read address and samples hit/data in its next cycle, so lookup is combinational from array state.
- MEM issues writes after an LW fill from the byte-wide RAM and after every store completes to RAM, keeping the cache coherent with memory.
- Only word-aligned, non-IO words are cached. Everything else misses and takes the byte-serial RAM path.

Parameters:
- INDEX_W, 7: index bits, giving 2^INDEX_W word entries (128).
- TAG_HI, 16: top address bit kept in the tag. Tag = addr[TAG_HI:INDEX_W+2]. RAM space is 128 KB.
- IO_HI, 17: address bit that marks the IO region (addr[17]=1 is IO). IO addresses are never cached.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- re_i  in  1  lookup request valid
- raddr_i  in  32  lookup byte address
- hit_o  out  1  `Hit when the word at raddr_i is cached, else `Miss
- data_o  out  32  cached word, little-endian; ZeroWord on miss
- we_i  in  1  write request; sampled at posedge
- wsize_i  in  2  write size: `SizeByte=0, `SizeHalf=1, `SizeWord=2
- waddr_i  in  32  write byte address
- wdata_i  in  32  write data, LSB-aligned (byte in [7:0], half in [15:0])

Behaviour:
- Storage:
  - valid[2^INDEX_W] flops, tag array, data array.
  - Index = addr[INDEX_W+1:2].
- Reset: valid cleared in one cycle when rst=1 at posedge. Arrays are not cleared.
- Outputs during/after reset: hit_o=`Miss and data_o=ZeroWord, since all entries are invalid.
- Lookup (combinational, zero latency): hit_o=`Hit iff all of the following hold, else hit_o=`Miss and data_o=ZeroWord.
  - re_i=1
  - raddr_i[1:0]=0
  - raddr_i[IO_HI]=0
  - valid[idx]=1
  - tag[idx]==raddr_i tag bits
- Lookup reflects array state before the current edge. A same-cycle write is not forwarded, because MEM never reads and writes in one cycle.
- Writes take effect at posedge when we_i=1 and rst=0. IO addresses (waddr_i[IO_HI]=1) are ignored.
- Word write, aligned (waddr[1:0]=0): data[idx]=wdata_i, tag[idx]=waddr tag, valid[idx]=1. Allocates unconditionally; this covers both LW fill and SW.
- Word write, unaligned: the write spans words W=waddr>>2 and W+1.
  - For each of the two words, invalidate its entry if valid and the tag matches.
  - The second word's index wraps modulo 2^INDEX_W; its tag is computed from waddr+4.
- Half write:
  - If waddr[1:0]=3, it spans two words; apply the same invalidate rule as an unaligned word write.
  - Otherwise, on a tag hit for the containing word, merge wdata_i[15:0] into byte lanes waddr[1:0] and waddr[1:0]+1.
  - On a tag miss: no allocate, no change.
- Byte write: on a tag hit for the containing word, merge wdata_i[7:0] into byte lane waddr[1:0]. On a miss, no change.
- Reserved wsize_i=3: treated as no write.
- rst and we_i in the same cycle: reset wins and the write is dropped.
- Conflict-free: only one write port, so there is no write-write collision. The two entries touched by an unaligned invalidate are always distinct (adjacent indices, 2^INDEX_W≥2).
- Width rules: byte-lane merge is done per lane with an enable mask. No arithmetic beyond waddr+4 (32-bit, wraps).

Decomposition:
- Shared defines.v adds:
  - `SizeByte, `SizeHalf, `SizeWord, `SizeBus[1:0]
  - `DcacheIndexW, `DcacheTagHi, `IoBit
- `Hit and `Miss already exist in defines.v.
- One natural sub-module, dcache_lane_merge: combinational, produces the 4-bit byte-enable and merged word from old data, wdata, size and offset.
- The tag/valid/data arrays and lookup logic stay in dcache.

Test Plan:
- Reset, then re_i=1, raddr=0x100 -> hit_o=`Miss, data_o=0x00000000.
- Word write 0x100←0xDEADBEEF, next cycle lookup 0x100 -> `Hit, data_o=0xDEADBEEF. Lookup 0x102 -> `Miss (unaligned).
- With 0x100 cached:
  - Byte write 0x101←0x55 -> lookup 0x100 gives 0xDEAD55EF.
  - Half write 0x102←0x1234 -> gives 0x123455EF.
  - Byte write 0x205 (uncached) -> entry 0x204 is still a miss.
- Alias/replace and unaligned invalidate:
  - Write 0x100←0x11111111, then 0x100+(4<<INDEX_W)=0x300←0x22222222 -> 0x100 misses, 0x300 hits 0x22222222.
  - Cache 0x300 and 0x304, then unaligned word write 0x302 -> both miss.
- IO and index wrap:
  - Word write 0x30000←0xAAAA -> no allocate; lookup 0x30000 misses.
  - Cache 0x1FC and 0x000; unaligned half write 0x1FF -> 0x1FC (index 127) and 0x200 (index 0, different tag) handled. 0x1FC is invalid; 0x000 is still a hit.
- Reset mid-operation: cache 0x100, assert rst together with word write 0x104 -> after the edge, both 0x100 and 0x104 miss.
